// File: rtl/apb2umi.sv
// APB slave to UMI host bridge. Each APB access becomes one single-word UMI
// request; the APB transfer completes once the matching UMI response arrives,
// when the access is rejected, or when the response wait times out.
module apb2umi #(
  parameter int             RAW      = 32,
  parameter int             AW       = 64,
  parameter int             CW       = 32,
  parameter int             DW       = 256,
  parameter int             RW       = 32,
  parameter logic [AW-1:0]  BASEADDR = '0,
  parameter logic [AW-1:0]  SRCADDR  = '0,
  parameter int             TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              nreset,
  // APB slave
  input  logic [RAW-1:0]    apb_paddr,
  input  logic [2:0]        apb_pprot,
  input  logic              apb_psel,
  input  logic              apb_penable,
  input  logic              apb_pwrite,
  input  logic [RW-1:0]     apb_pwdata,
  input  logic [RW/8-1:0]   apb_pstrb,
  output logic              apb_pready,
  output logic [RW-1:0]     apb_prdata,
  output logic              apb_pslverr,
  // UMI host request
  output logic              uhost_req_valid,
  output logic [CW-1:0]     uhost_req_cmd,
  output logic [AW-1:0]     uhost_req_dstaddr,
  output logic [AW-1:0]     uhost_req_srcaddr,
  output logic [DW-1:0]     uhost_req_data,
  input  logic              uhost_req_ready,
  // UMI host response
  input  logic              uhost_resp_valid,
  input  logic [CW-1:0]     uhost_resp_cmd,
  input  logic [AW-1:0]     uhost_resp_dstaddr,
  input  logic [AW-1:0]     uhost_resp_srcaddr,
  input  logic [DW-1:0]     uhost_resp_data,
  output logic              uhost_resp_ready
);

  localparam int         BW   = RW / 8;
  localparam logic [2:0] SIZE = 3'($clog2(BW));
  localparam int         TCW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t           state, state_n;
  logic             stale;
  logic [TCW-1:0]   tcnt;
  logic             req_write;
  logic [CW-1:0]    req_cmd;
  logic [AW-1:0]    req_dst;
  logic [AW-1:0]    req_src;
  logic [RW-1:0]    req_wdata;
  logic [RW-1:0]    prdata_q;
  logic             pslverr_q;

  logic access, strb_ok, capture, req_hs, resp_hs, stale_drop, timeout_hit;

  // Single-word request command: opcode, size, protection, end of message/frame.
  function automatic logic [CW-1:0] build_cmd(input logic wr, input logic [2:0] prot);
    logic [CW-1:0] c;
    c        = '0;
    c[4:0]   = wr ? REQ_WRITE : REQ_READ;
    c[7:5]   = SIZE;
    c[21:20] = prot[1:0];
    c[22]    = 1'b1;
    c[23]    = 1'b1;
    return c;
  endfunction

  // A response is bad when it carries an error code or the wrong opcode.
  function automatic logic resp_bad(input logic [CW-1:0] c, input logic wr);
    return (c[26:25] != 2'b00) || (c[4:0] != (wr ? RESP_WRITE : RESP_READ));
  endfunction

  assign access      = apb_psel & apb_penable;
  assign strb_ok     = &apb_pstrb;
  assign capture     = (state == IDLE) && access && strb_ok;
  // The request is held back until any late response has been flushed.
  assign uhost_req_valid  = (state == REQ) && !stale;
  assign uhost_resp_ready = (state == RESP) || (stale && ((state == IDLE) || (state == REQ)));
  assign req_hs      = uhost_req_valid && uhost_req_ready;
  assign resp_hs     = (state == RESP) && uhost_resp_valid;
  assign stale_drop  = stale && uhost_resp_valid && uhost_resp_ready;
  // REQ plus RESP may last TIMEOUT cycles in total before the wait is abandoned.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TCW'(TIMEOUT - 1));

  assign uhost_req_cmd     = req_cmd;
  assign uhost_req_dstaddr = req_dst;
  assign uhost_req_srcaddr = req_src;
  assign uhost_req_data    = {{(DW-RW){1'b0}}, req_wdata};

  assign apb_pready  = (state == DONE);
  assign apb_prdata  = apb_pready ? prdata_q : '0;
  assign apb_pslverr = apb_pready & pslverr_q;

  // Next-state decode for the transfer sequencer.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (access) state_n = strb_ok ? REQ : DONE;
      REQ:  if (req_hs) state_n = RESP;
            else if (timeout_hit) state_n = DONE;
      RESP: if (resp_hs || timeout_hit) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control state, timeout counter, stale flag and the held request fields.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      stale     <= 1'b0;
      tcnt      <= '0;
      req_write <= 1'b0;
      req_cmd   <= '0;
      req_dst   <= '0;
      req_src   <= '0;
      req_wdata <= '0;
    end else begin
      state <= state_n;
      if ((state == REQ) || (state == RESP)) tcnt <= tcnt + TCW'(1);
      else                                   tcnt <= '0;
      if ((state == RESP) && !resp_hs && timeout_hit) stale <= 1'b1;
      else if (stale_drop)                            stale <= 1'b0;
      if (capture) begin
        req_write <= apb_pwrite;
        req_cmd   <= build_cmd(apb_pwrite, apb_pprot);
        req_dst   <= BASEADDR + (AW'(apb_paddr) & ~AW'(BW - 1));
        req_src   <= SRCADDR;
        req_wdata <= apb_pwdata;
      end
    end
  end

  // Completion data and error status; only observed while in DONE.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (access) begin
              prdata_q  <= '0;
              pslverr_q <= !strb_ok;
            end
      REQ:  if (!req_hs && timeout_hit) pslverr_q <= 1'b1;
      RESP: if (resp_hs) begin
              pslverr_q <= resp_bad(uhost_resp_cmd, req_write);
              prdata_q  <= req_write ? '0 : uhost_resp_data[RW-1:0];
            end else if (timeout_hit) begin
              pslverr_q <= 1'b1;
            end
      default: ;
    endcase
  end

  logic unused_inputs;
  assign unused_inputs = ^{apb_pprot[2], uhost_resp_cmd[CW-1:27], uhost_resp_cmd[24:5],
                           uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data[DW-1:RW]};

endmodule
